bound_flasher_n: RTL and testbench

Parametrised bound flasher: drives an N-lamp thermometer-coded LED bar through the six-phase on/off sweep with two kickback points, started by `flick`. Successor to the fixed 16-lamp flasher; it generalises lamp count, both bound positions and step rate, and adds a busy flag. It sits directly behind the board LED pins, clocked from the system clock.

---
 rtl/bound_flasher_n.sv | 79 +++++++
 tb/tb_bound_flasher_n.sv | 136 +++++++++++++
 2 files changed

// File: rtl/bound_flasher_n.sv
// bound_flasher_n: N-lamp thermometer bar sweeping through six up/down phases with two flick kickbacks.
// Defining BOUND_FLASHER_PAUSE_EN adds a pause input that freezes the sweep.
module bound_flasher_n #(
    parameter int N   = 16,
    parameter int B1  = 5,
    parameter int B2  = 10,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flick,
`ifdef BOUND_FLASHER_PAUSE_EN
    input  logic         pause,
`endif
    output logic [N-1:0] led,
    output logic         busy
);
    localparam int LW = $clog2(N + 1);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    typedef enum logic [2:0] {IDLE, UP1, DN1, UP2, DN2, UP3, DN3} state_t;
    state_t state, state_nx;
    logic [LW-1:0] lvl, lvl_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [N-1:0] led_nx;
    logic tick, hold, up;
`ifdef BOUND_FLASHER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif
    assign tick = cnt == CW'(DIV - 1);
    assign up = state == UP1 || state == UP2 || state == UP3;
    always_comb begin
        state_nx = state;
        lvl_nx = lvl;
        cnt_nx = cnt;
        if (!hold && state == IDLE) begin
            cnt_nx = '0;
            lvl_nx = '0;
            state_nx = flick ? UP1 : IDLE;
        end else if (!hold) begin
            cnt_nx = tick ? '0 : cnt + CW'(1);
            if (tick) begin
                lvl_nx = up ? lvl + LW'(1) : lvl - LW'(1);
                // Targets win; kickbacks only fire on their exact level with flick high.
                case (state)
                    UP1: state_nx = lvl_nx == LW'(B1 + 1) ? DN1 : UP1;
                    DN1: state_nx = lvl_nx == '0 ? UP2 : DN1;
                    UP2: state_nx = lvl_nx == LW'(B2 + 1) ? DN2 :
                                    (lvl_nx == LW'(B1 + 1) && flick) ? DN1 : UP2;
                    DN2: state_nx = lvl_nx == LW'(B1) ? UP3 : DN2;
                    UP3: state_nx = lvl_nx == LW'(N) ? DN3 :
                                    (lvl_nx == LW'(B2 + 1) && flick) ? DN2 : UP3;
                    DN3: state_nx = lvl_nx == '0 ? IDLE : DN3;
                    default: state_nx = IDLE;
                endcase
            end
        end
    end
    always_comb begin
        led_nx = '0;
        for (int k = 0; k < N; k++) led_nx[k] = k < int'(lvl_nx);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lvl <= '0;
            cnt <= '0;
            led <= '0;
            busy <= 1'b0;
        end else begin
            state <= state_nx;
            lvl <= lvl_nx;
            cnt <= cnt_nx;
            led <= led_nx;
            busy <= state_nx != IDLE;
        end
    end
endmodule

// File: tb/tb_bound_flasher_n.sv
// tb_bound_flasher_n: directed checks of the default flasher and an N=8, DIV=3 variant.
module tb_bound_flasher_n;
    logic clk = 0, rst = 1, flick = 0, pause = 0;
    logic rst2 = 1, flick2 = 0, pause2 = 0;
    logic [15:0] led;
    logic [7:0] led2;
    logic busy, busy2;
    int passed = 0, total = 0, lv = 0, lv2 = 0;
    always #5 clk = ~clk;
    bound_flasher_n dut (
        .clk(clk), .rst(rst), .flick(flick),
`ifdef BOUND_FLASHER_PAUSE_EN
        .pause(pause),
`endif
        .led(led), .busy(busy)
    );
    bound_flasher_n #(.N(8), .B1(2), .B2(5), .DIV(3)) dut2 (
        .clk(clk), .rst(rst2), .flick(flick2),
`ifdef BOUND_FLASHER_PAUSE_EN
        .pause(pause2),
`endif
        .led(led2), .busy(busy2)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [31:0] therm(input int l);
        return (32'd1 << l) - 32'd1;
    endfunction
    task automatic run_to(input int target, input int kick, input bit fin);
        int dir, n;
        dir = target > lv ? 1 : -1;
        n = 0;
        while (lv != target && n < 64) begin
            if (kick >= 0) flick = (lv + dir == kick);
            step();
            lv += dir;
            n++;
            check("led", {16'd0, led}, therm(lv));
            check("busy", {31'd0, busy}, {31'd0, !(fin && lv == target)});
        end
        if (kick >= 0) flick = 0;
    endtask
    task automatic start();
        flick = 1;
        step();
        check("start_busy", {31'd0, busy}, 1);
        check("start_led", {16'd0, led}, 0);
        flick = 0;
        lv = 0;
    endtask
    task automatic run2_to(input int target, input bit fin);
        int dir;
        dir = target > lv2 ? 1 : -1;
        while (lv2 != target) begin
            step();
            check("p_hold1", {24'd0, led2}, therm(lv2));
            step();
            check("p_hold2", {24'd0, led2}, therm(lv2));
            step();
            lv2 += dir;
            check("p_led", {24'd0, led2}, therm(lv2));
            check("p_busy", {31'd0, busy2}, {31'd0, !(fin && lv2 == target)});
        end
    endtask
    initial begin
        step();
        step();
        rst = 0;
        check("rst_led", {16'd0, led}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        step();
        check("idle_busy", {31'd0, busy}, 0);
        start();
        run_to(6, -1, 0); run_to(0, -1, 0); run_to(11, -1, 0);
        run_to(5, -1, 0); run_to(16, -1, 0); run_to(0, -1, 1);
        start();
        run_to(6, -1, 0); run_to(0, -1, 0);
        flick = 1;
        run_to(6, -1, 0); run_to(0, -1, 0); run_to(6, -1, 0); run_to(0, -1, 0);
        flick = 0;
        run_to(11, -1, 0); run_to(5, -1, 0); run_to(16, -1, 0); run_to(0, -1, 1);
        step();
        check("after_sweep_busy", {31'd0, busy}, 0);
        start();
        run_to(6, -1, 0); run_to(0, -1, 0); run_to(11, -1, 0); run_to(5, -1, 0);
        run_to(11, 11, 0); run_to(5, -1, 0); run_to(16, -1, 0); run_to(0, -1, 1);
        start();
        run_to(6, -1, 0); run_to(0, -1, 0); run_to(11, -1, 0); run_to(5, -1, 0); run_to(16, -1, 0);
        rst = 1;
        flick = 1;
        step();
        check("mid_rst_led", {16'd0, led}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        rst = 0;
        flick = 0;
        repeat (4) begin
            step();
            check("post_rst_led", {16'd0, led}, 0);
            check("post_rst_busy", {31'd0, busy}, 0);
        end
`ifdef BOUND_FLASHER_PAUSE_EN
        start();
        run_to(6, -1, 0); run_to(0, -1, 0); run_to(8, -1, 0);
        pause = 1;
        repeat (10) begin
            step();
            check("pause_led", {16'd0, led}, 32'h00FF);
            check("pause_busy", {31'd0, busy}, 1);
        end
        pause = 0;
        run_to(11, -1, 0); run_to(5, -1, 0); run_to(16, -1, 0); run_to(0, -1, 1);
`endif
        rst2 = 0;
        step();
        check("p_rst_led", {24'd0, led2}, 0);
        check("p_rst_busy", {31'd0, busy2}, 0);
        flick2 = 1;
        step();
        flick2 = 0;
        check("p_start_busy", {31'd0, busy2}, 1);
        check("p_start_led", {24'd0, led2}, 0);
        lv2 = 0;
        run2_to(3, 0); run2_to(0, 0); run2_to(6, 0); run2_to(2, 0); run2_to(8, 0); run2_to(0, 1);
        step();
        check("p_idle_busy", {31'd0, busy2}, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
